// File: rtl/ahb_mem_fill_master.sv
// AHB-Lite master that fills a word-aligned region with a constant or incrementing
// pattern using pipelined single transfers, and can read the region back to verify it.
module ahb_mem_fill_master #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RES_N,
    input  logic                 START,
    input  logic                 VERIFY,
    input  logic                 INCR,
    input  logic [31:0]          BASE_ADDR,
    input  logic [CNT_WIDTH-1:0] WORD_COUNT,
    input  logic [31:0]          PATTERN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERROR,
    output logic [31:0]          ERR_ADDR,
    output logic [1:0]           M_HTRANS,
    output logic                 M_HWRITE,
    output logic [2:0]           M_HSIZE,
    output logic [2:0]           M_HBURST,
    output logic [3:0]           M_HPROT,
    output logic                 M_HMASTLOCK,
    output logic [31:0]          M_HADDR,
    output logic [31:0]          M_HWDATA,
    input  logic                 M_HREADY,
    input  logic [31:0]          M_HRDATA,
    input  logic                 M_HRESP
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_LAST = 3'd2,
        S_RD      = 3'd3,
        S_RD_LAST = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    state_t               state_q;
    logic                 busy_q, done_q, err_q, hwrite_q;
    logic                 verify_q, incr_q, dph_q, dph_rd_q;
    logic [1:0]           htrans_q;
    logic [31:0]          err_addr_q, addr_q, hwdata_q, base_q, seed_q, data_q;
    logic [31:0]          dph_addr_q, exp_q;
    logic [CNT_WIDTH-1:0] cnt_q, rem_q;

    logic [31:0]          addr_d, data_d;
    logic [CNT_WIDTH-1:0] rem_d;
    logic                 last_d, accept_d, mism_d, resp_err_d;

    // Next-value helpers shared by the write and read passes
    always_comb begin
        addr_d     = addr_q + 32'd4;
        data_d     = incr_q ? (data_q + 32'd1) : data_q;
        rem_d      = rem_q - CNT_ONE;
        last_d     = (rem_q == CNT_ONE);
        accept_d   = M_HREADY && htrans_q[1];
        // Only the first mismatch is checked; later data phases just drain.
        mism_d     = M_HREADY && dph_q && dph_rd_q && !err_q && !M_HRESP && (M_HRDATA != exp_q);
        resp_err_d = dph_q && M_HRESP && !M_HREADY;
    end

    // Control FSM with all bus and status outputs registered
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0000_0000;
            htrans_q   <= 2'b00;
            hwrite_q   <= 1'b0;
            addr_q     <= 32'h0000_0000;
            hwdata_q   <= 32'h0000_0000;
            verify_q   <= 1'b0;
            incr_q     <= 1'b0;
            base_q     <= 32'h0000_0000;
            seed_q     <= 32'h0000_0000;
            data_q     <= 32'h0000_0000;
            cnt_q      <= CNT_ZERO;
            rem_q      <= CNT_ZERO;
            dph_q      <= 1'b0;
            dph_rd_q   <= 1'b0;
            dph_addr_q <= 32'h0000_0000;
            exp_q      <= 32'h0000_0000;
        end else if (resp_err_d) begin
            // First ERROR cycle: drop to IDLE now and drain the failing data phase.
            htrans_q <= 2'b00;
            err_q    <= 1'b1;
            if (!err_q) begin
                err_addr_q <= dph_addr_q;
            end
            state_q <= S_RD_LAST;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        verify_q   <= VERIFY;
                        incr_q     <= INCR;
                        base_q     <= BASE_ADDR & 32'hFFFF_FFFC;
                        addr_q     <= BASE_ADDR & 32'hFFFF_FFFC;
                        cnt_q      <= WORD_COUNT;
                        rem_q      <= WORD_COUNT;
                        seed_q     <= PATTERN;
                        data_q     <= PATTERN;
                        err_q      <= 1'b0;
                        err_addr_q <= 32'h0000_0000;
                        busy_q     <= 1'b1;
                        dph_q      <= 1'b0;
                        if (WORD_COUNT == CNT_ZERO) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q  <= S_WR;
                            htrans_q <= 2'b10;
                            hwrite_q <= 1'b1;
                        end
                    end
                end
                S_WR, S_RD: begin
                    if (accept_d) begin
                        dph_q      <= 1'b1;
                        dph_rd_q   <= !hwrite_q;
                        dph_addr_q <= addr_q;
                        exp_q      <= data_q;
                        if (hwrite_q) begin
                            hwdata_q <= data_q;
                        end
                        addr_q <= addr_d;
                        rem_q  <= rem_d;
                        data_q <= data_d;
                        if (last_d) begin
                            htrans_q <= 2'b00;
                            state_q  <= (state_q == S_WR) ? S_WR_LAST : S_RD_LAST;
                        end
                    end
                    if (mism_d) begin
                        err_q      <= 1'b1;
                        err_addr_q <= dph_addr_q;
                        htrans_q   <= 2'b00;
                        state_q    <= S_RD_LAST;
                    end
                end
                S_WR_LAST: begin
                    if (M_HREADY) begin
                        dph_q <= 1'b0;
                        if (verify_q) begin
                            addr_q   <= base_q;
                            rem_q    <= cnt_q;
                            data_q   <= seed_q;
                            htrans_q <= 2'b10;
                            hwrite_q <= 1'b0;
                            state_q  <= S_RD;
                        end else begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_RD_LAST: begin
                    if (M_HREADY) begin
                        if (mism_d) begin
                            err_q      <= 1'b1;
                            err_addr_q <= dph_addr_q;
                        end
                        dph_q   <= 1'b0;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    hwrite_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    htrans_q <= 2'b00;
                    busy_q   <= 1'b0;
                    dph_q    <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ERROR       = err_q;
    assign ERR_ADDR    = err_addr_q;
    assign M_HTRANS    = htrans_q;
    assign M_HWRITE    = hwrite_q;
    assign M_HADDR     = addr_q;
    assign M_HWDATA    = hwdata_q;
    assign M_HSIZE     = 3'b010;
    assign M_HBURST    = 3'b000;
    assign M_HPROT     = 4'b0011;
    assign M_HMASTLOCK = 1'b0;
endmodule

// File: tb/tb_ahb_mem_fill_master.sv
// Bench for ahb_mem_fill_master: RAM slave model with optional wait states, read
// corruption and ERROR responses, plus a table of directed fill/verify runs.
module tb_ahb_mem_fill_master;
    logic        CLK = 1'b0;
    logic        RES_N = 1'b0;
    logic        START = 1'b0, VERIFY = 1'b0, INCR = 1'b0;
    logic [31:0] BASE_ADDR = 32'h0, PATTERN = 32'h0;
    logic [15:0] WORD_COUNT = 16'h0;
    logic        BUSY, DONE, ERROR, M_HWRITE, M_HMASTLOCK, M_HREADY, M_HRESP;
    logic [31:0] ERR_ADDR, M_HADDR, M_HWDATA, M_HRDATA;
    logic [1:0]  M_HTRANS;
    logic [2:0]  M_HSIZE, M_HBURST;
    logic [3:0]  M_HPROT;

    ahb_mem_fill_master #(.CNT_WIDTH(16)) dut (
        .CLK(CLK), .RES_N(RES_N), .START(START), .VERIFY(VERIFY), .INCR(INCR),
        .BASE_ADDR(BASE_ADDR), .WORD_COUNT(WORD_COUNT), .PATTERN(PATTERN),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_ADDR(ERR_ADDR),
        .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST),
        .M_HPROT(M_HPROT), .M_HMASTLOCK(M_HMASTLOCK), .M_HADDR(M_HADDR), .M_HWDATA(M_HWDATA),
        .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int stab_bad = 0;

    // RAM slave model: waits keyed on HADDR[3:2], optional two-cycle ERROR response
    logic [31:0] mem [0:4095];
    logic        dp_valid, dp_write, dp_err;
    logic [31:0] dp_addr;
    logic [1:0]  wcnt;
    bit          wait_en = 1'b0, inj_en = 1'b0, cor_en = 1'b0, clr_req = 1'b0;
    logic [31:0] inj_addr = 32'h0, cor_addr = 32'h0;

    always @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_err   <= 1'b0;
            dp_addr  <= 32'h0;
            wcnt     <= 2'd0;
        end else begin
            if (clr_req) begin
                for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            end
            if (M_HREADY) begin
                if (dp_valid && dp_write && !dp_err) mem[dp_addr[13:2]] <= M_HWDATA;
                dp_valid <= (M_HTRANS == 2'b10);
                dp_write <= M_HWRITE;
                dp_addr  <= M_HADDR;
                dp_err   <= inj_en && (M_HTRANS == 2'b10) && (M_HADDR == inj_addr);
                if (inj_en && (M_HADDR == inj_addr)) wcnt <= 2'd1;
                else wcnt <= wait_en ? M_HADDR[3:2] : 2'd0;
            end else begin
                wcnt <= wcnt - 2'd1;
            end
        end
    end

    assign M_HREADY = !(dp_valid && (wcnt != 2'd0));
    assign M_HRESP  = dp_valid && dp_err;
    assign M_HRDATA = (dp_valid && !dp_write) ?
                      (mem[dp_addr[13:2]] ^ ((cor_en && (dp_addr == cor_addr)) ? 32'h0000_0100 : 32'h0)) : 32'h0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Bus monitor: log accepted address phases, count DONE pulses, check hold stability
    logic [31:0] ph_addr[$];
    bit          ph_wr[$];
    int          ph_cyc[$];
    logic        prv_ok = 1'b0, prv_hready = 1'b1, prv_hresp = 1'b0, prv_hwrite = 1'b0, prv_wdp = 1'b0;
    logic [1:0]  prv_htrans = 2'b00;
    logic [31:0] prv_haddr = 32'h0, prv_hwdata = 32'h0;

    always @(negedge CLK) begin
        if (RES_N && M_HREADY && (M_HTRANS == 2'b10)) begin
            ph_addr.push_back(M_HADDR);
            ph_wr.push_back(M_HWRITE);
            ph_cyc.push_back(cyc);
        end
        if (DONE) done_cnt <= done_cnt + 1;
        if (RES_N && prv_ok && !prv_hready && !prv_hresp) begin
            if ((prv_htrans == 2'b10) && ((M_HTRANS != prv_htrans) || (M_HADDR != prv_haddr) ||
                (M_HWRITE != prv_hwrite))) stab_bad <= stab_bad + 1;
            else if (prv_wdp && (M_HWDATA != prv_hwdata)) stab_bad <= stab_bad + 1;
        end
        prv_ok     <= RES_N;
        prv_hready <= M_HREADY;
        prv_hresp  <= M_HRESP;
        prv_htrans <= M_HTRANS;
        prv_haddr  <= M_HADDR;
        prv_hwrite <= M_HWRITE;
        prv_hwdata <= M_HWDATA;
        prv_wdp    <= dp_valid && dp_write;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int st, output int lat);
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            if (DONE === 1'b1) begin
                lat = cyc - st;
                break;
            end
            @(negedge CLK);
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no DONE want DONE within 400 cycles");
        end
    endtask

    task automatic setup_env(input bit w, input bit inj, input bit cor, input logic [31:0] a);
        @(negedge CLK);
        clr_req  = 1'b1;
        wait_en  = w;
        inj_en   = inj;
        cor_en   = cor;
        inj_addr = a;
        cor_addr = a;
        @(negedge CLK);
        clr_req = 1'b0;
    endtask

    typedef struct {
        logic [31:0] base;
        int          n;
        logic [31:0] pat;
        bit          incr, ver, waits, corrupt, inject;
        logic [31:0] bad_addr;
        int          exp_lat;     // 0 = not checked
        bit          exp_err;
        logic [31:0] exp_ea;
        int          exp_nph;
        bit          chk_mem;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int id, input vec_t v);
        int st, lat, lb, d0, nb, bseq, bmem;
        logic [31:0] bal, ea, wexp;
        bit ewr;
        int ecyc;
        setup_env(v.waits, v.inject, v.corrupt, v.bad_addr);
        BASE_ADDR  = v.base;
        WORD_COUNT = v.n[15:0];
        PATTERN    = v.pat;
        INCR       = v.incr;
        VERIFY     = v.ver;
        START      = 1'b1;
        st = cyc;
        lb = ph_addr.size();
        d0 = done_cnt;
        @(negedge CLK);
        START = 1'b0;
        chk($sformatf("v%0d_busy_rise", id), BUSY, 1'b1);
        wait_done(st, lat);
        if (lat >= 0) begin
            if (v.exp_lat > 0) chk($sformatf("v%0d_latency", id), lat, v.exp_lat);
            chk($sformatf("v%0d_busy_at_done", id), BUSY, 1'b0);
        end
        chk($sformatf("v%0d_error", id), ERROR, v.exp_err);
        chk($sformatf("v%0d_err_addr", id), ERR_ADDR, v.exp_ea);
        repeat (3) @(negedge CLK);
        chk($sformatf("v%0d_done_pulses", id), done_cnt - d0, 1);
        nb = ph_addr.size() - lb;
        chk($sformatf("v%0d_phase_count", id), nb, v.exp_nph);
        bal = v.base & 32'hFFFF_FFFC;
        bseq = 0;
        for (int j = 0; j < nb; j++) begin
            ewr  = (j < v.n);
            ea   = bal + 32'(4 * (ewr ? j : j - v.n));
            ecyc = ewr ? st + 1 + j : st + v.n + 2 + (j - v.n);
            if ((ph_addr[lb + j] != ea) || (ph_wr[lb + j] != ewr)) bseq++;
            if (!v.waits && (ph_cyc[lb + j] != ecyc)) bseq++;
        end
        chk($sformatf("v%0d_addr_seq", id), bseq, 0);
        if (v.chk_mem) begin
            bmem = 0;
            for (int i = 0; i < v.n; i++) begin
                ea   = bal + 32'(4 * i);
                wexp = v.pat + (v.incr ? 32'(i) : 32'h0);
                if (mem[ea[13:2]] !== wexp) bmem++;
            end
            chk($sformatf("v%0d_mem", id), bmem, 0);
        end
    endtask

    initial begin
        int st, lat, lb, d0;
        logic [31:0] tmp;
        vecs[0] = '{32'h0000_0100, 4, 32'hA5A5_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 7, 1'b0, 32'h0, 4, 1'b1};
        vecs[1] = '{32'h0000_0100, 4, 32'hA5A5_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 4, 1'b1};
        vecs[2] = '{32'h0000_0400, 8, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 20, 1'b0, 32'h0, 16, 1'b1};
        vecs[3] = '{32'h0000_2000, 8, 32'h1234_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2014, 19, 1'b1, 32'h2014, 15, 1'b1};
        vecs[4] = '{32'h0000_0300, 0, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2, 1'b0, 32'h0, 0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFC, 2, 32'h0000_0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8, 1'b0, 32'h0, 4, 1'b1};
        vecs[6] = '{32'h0000_0503, 3, 32'hCAFE_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0, 6, 1'b1};
        vecs[7] = '{32'h0000_0600, 4, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h608, 7, 1'b1, 32'h608, 3, 1'b0};

        #12;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_error", ERROR, 1'b0);
        chk("rst_err_addr", ERR_ADDR, 32'h0);
        chk("rst_htrans", M_HTRANS, 2'b00);
        chk("rst_hwrite", M_HWRITE, 1'b0);
        chk("rst_haddr", M_HADDR, 32'h0);
        chk("rst_hwdata", M_HWDATA, 32'h0);
        tmp = {20'h0, M_HSIZE, M_HBURST, M_HPROT, 1'b0, M_HMASTLOCK};
        chk("const_ctrl", tmp, {20'h0, 3'b010, 3'b000, 4'b0011, 1'b0, 1'b0});
        @(negedge CLK);
        RES_N = 1'b1;

        for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);

        repeat (4) @(negedge CLK);
        chk("err_sticky", ERROR, 1'b1);
        chk("err_addr_sticky", ERR_ADDR, 32'h608);

        // START while busy must be ignored, including its changed inputs
        setup_env(1'b0, 1'b0, 1'b0, 32'h0);
        BASE_ADDR = 32'h800; WORD_COUNT = 16'd8; PATTERN = 32'h5; INCR = 1'b1; VERIFY = 1'b0;
        START = 1'b1;
        st = cyc; lb = ph_addr.size(); d0 = done_cnt;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        BASE_ADDR = 32'h9000; WORD_COUNT = 16'd1; PATTERN = 32'hFFFF_0000; INCR = 1'b0; VERIFY = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(st, lat);
        chk("busy_start_latency", lat, 11);
        repeat (6) @(negedge CLK);
        chk("busy_start_phases", ph_addr.size() - lb, 8);
        chk("busy_start_done_pulses", done_cnt - d0, 1);
        chk("busy_start_mem0", mem[12'h200], 32'h5);
        chk("busy_start_mem7", mem[12'h207], 32'hC);

        // Asynchronous reset in the middle of the write pass
        setup_env(1'b0, 1'b0, 1'b0, 32'h0);
        BASE_ADDR = 32'hA00; WORD_COUNT = 16'd8; PATTERN = 32'h0; INCR = 1'b1; VERIFY = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        chk("pre_reset_htrans", M_HTRANS, 2'b10);
        #1 RES_N = 1'b0;
        #1;
        chk("async_rst_htrans", M_HTRANS, 2'b00);
        chk("async_rst_busy", BUSY, 1'b0);
        chk("async_rst_error", ERROR, 1'b0);
        d0 = done_cnt;
        repeat (3) @(negedge CLK);
        RES_N = 1'b1;
        repeat (12) @(negedge CLK);
        chk("no_done_after_reset", done_cnt - d0, 0);
        chk("idle_after_reset", BUSY, 1'b0);
        run_vec(99, vecs[0]);

        chk("bus_stable", stab_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb_mem_fill_master.md
Name: ahb_mem_fill_master

Overview:
- AHB-Lite master engine directly upstream of the RAM slave. It fills a word-aligned memory region with a constant or incrementing pattern, and can optionally read the region back to verify it.
- Used for boot-time RAM clear and for self-test. Its master port connects through the bus matrix to the RAM slave's S_H* port.
- Issues pipelined single word transfers, so the address phase of word i+1 overlaps the data phase of word i.

Parameters:
- CNT_WIDTH, 16, width of the word-count register (maximum region = 2^CNT_WIDTH - 1 words).

Ports:
- CLK  input  1  system clock
- RES_N  input  1  reset, asynchronous, active-low
- START  input  1  one-cycle start pulse; ignored while BUSY=1
- VERIFY  input  1  1 = fill then read back and compare; 0 = fill only (sampled at START)
- INCR  input  1  1 = data of word i is PATTERN+i (mod 2^32); 0 = data is PATTERN (sampled at START)
- BASE_ADDR  input  32  start byte address; bits [1:0] are ignored and treated as 00 (sampled at START)
- WORD_COUNT  input  CNT_WIDTH  number of words to process (sampled at START)
- PATTERN  input  32  fill seed (sampled at START)
- BUSY  output  1  high from the cycle after an accepted START until DONE is asserted
- DONE  output  1  one-cycle completion pulse
- ERROR  output  1  sticky; cleared by the next accepted START
- ERR_ADDR  output  32  address of the first failing word (compare mismatch or HRESP error)
- M_HTRANS  output  2  IDLE (00) or NONSEQ (10) only
- M_HWRITE  output  1  transfer direction
- M_HSIZE  output  3  constant 3'b010 (word)
- M_HBURST  output  3  constant 3'b000 (SINGLE)
- M_HPROT  output  4  constant 4'b0011
- M_HMASTLOCK  output  1  constant 0
- M_HADDR  output  32  transfer address
- M_HWDATA  output  32  write data, valid in the data phase
- M_HREADY  input  1  bus ready
- M_HRDATA  input  32  read data
- M_HRESP  input  1  1 = ERROR response

Behaviour:
- Reset values of all outputs:
  - BUSY=0, DONE=0, ERROR=0, ERR_ADDR=0.
  - M_HTRANS=IDLE, M_HWRITE=0, M_HADDR=0, M_HWDATA=0.
  - Reset is asynchronous and may abort a transfer in flight. All internal state returns to IDLE; no DONE pulse is generated.
- FSM states: IDLE, WR, WR_LAST, RD, RD_LAST, FIN.
- IDLE:
  - On START: latch all inputs, set addr=BASE_ADDR&~3, set remaining=WORD_COUNT, clear ERROR and ERR_ADDR.
  - If WORD_COUNT=0, go to FIN and issue no bus transfer. Otherwise go to WR.
- WR:
  - Drive NONSEQ, HWRITE=1, HADDR=addr.
  - On each cycle with M_HREADY=1: the address phase is accepted; HWDATA for that word is registered to appear in the next cycle; addr+=4 (wraps at 2^32); remaining-=1.
  - When the last address phase is accepted, go to WR_LAST and drive IDLE.
- M_HREADY=0: HTRANS, HADDR, HWRITE and HWDATA are held stable. No counter advances.
- WR_LAST:
  - Wait for the final data phase to complete (M_HREADY=1).
  - Then go to RD if VERIFY=1, otherwise to FIN. For RD, reload addr and remaining and restart the pattern index at 0.
- RD:
  - Same pipelining as WR, with HWRITE=0.
  - In each data phase where M_HREADY=1, compare M_HRDATA with the expected pattern for that word's index.
  - On the first mismatch: set ERROR=1, set ERR_ADDR to that word's address, stop issuing address phases (drive IDLE), and go to RD_LAST.
  - A further address phase already accepted is completed but not checked.
- RD_LAST: wait for the outstanding data phase to complete, then go to FIN.
- FIN: DONE=1 for exactly one cycle; BUSY=0 in the same cycle; then go to IDLE.
- BUSY timing: BUSY=1 from the cycle after the START cycle until the cycle before FIN.
- HRESP handling:
  - M_HRESP=1 with M_HREADY=0 is the first error cycle. The master drives IDLE in the following cycle, as AHB-Lite requires.
  - It sets ERROR=1 and, if no error has yet been recorded, sets ERR_ADDR to the address of the failing data phase.
  - It then goes to FIN once M_HREADY=1.
- Throughput: with zero wait states, N words take N+1 bus cycles per pass.
  - Fill only: START to DONE = N+3 cycles.
  - Fill plus verify: START to DONE = 2N+4 cycles.
- Write-to-read turnaround: the first read address phase is issued only after the last write data phase has completed. The slave may therefore forward the written data or read it directly; both are legal.
- Pattern arithmetic: modulo 2^32. Index i runs from 0 to N-1 within each pass.

Test Plan:
- Fill, no wait states:
  - Stimulus: BASE=0x100, N=4, PATTERN=0xA5A50000, INCR=1, VERIFY=0, zero-wait RAM.
  - Required: HADDR=0x100, 0x104, 0x108, 0x10C on consecutive cycles; HWDATA=0xA5A50000..0xA5A50003, each one cycle later; DONE 7 cycles after START.
- Wait states:
  - Stimulus: same transfer, RAM inserts 0-3 waits keyed on HADDR[3:2].
  - Required: HADDR, HTRANS and HWDATA held stable while HREADY=0; final memory contents identical to the zero-wait case.
- Verify pass:
  - Stimulus: N=8, INCR=0, PATTERN=0xDEADBEEF, VERIFY=1.
  - Required: 8 writes then 8 reads; ERROR=0; DONE pulses once.
- Verify fail:
  - Stimulus: the bench corrupts word 5 between the passes (BASE=0x2000).
  - Required: ERROR=1; ERR_ADDR=0x2014; no address phase issued beyond 0x2018; DONE pulses once.
- Edge cases:
  - WORD_COUNT=0: DONE 2 cycles after START with no NONSEQ.
  - START while BUSY: ignored.
  - BASE_ADDR=0xFFFFFFFC, N=2: addresses 0xFFFFFFFC then 0x00000000.
- Reset mid-operation:
  - Stimulus: assert RES_N=0 during WR.
  - Required: HTRANS=IDLE, BUSY=0 and ERROR=0 asynchronously; no DONE pulse; a new START after reset runs normally.
